proj_sorter_ctrl: RTL and testbench

Sequencing controller for the MinHash smallest-K sorter. It accepts a per-document stream of (signature, index) beats from the hasher over a valid/ready handshake, clears the sorter between documents, and pads idle cycles with non-inserting filler. It then waits out the sorter pipeline, asserts end-of-sort, and hands the K smallest indices to the extender over a valid/ready handshake.

---
 rtl/proj_sorter_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_proj_sorter_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_sorter_ctrl.sv
// Sequencing controller for the MinHash smallest-K sorter.
// Streams hasher beats into the sorter and clears the sorter between documents.
// Pads idle cycles with non-inserting filler, waits out the sorter pipeline,
// then presents the captured K smallest indices to the extender.
module proj_sorter_ctrl #(
    parameter int INDICES_COUNT = 16,
    parameter int INDICE_LEN    = 16,
    parameter int SIGNATURE_LEN = 32,
    parameter int DRAIN_CYCLES  = 2,
    parameter int CNT_LEN       = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SIGNATURE_LEN-1:0]            in_signature,
    input  logic [INDICE_LEN-1:0]               in_index,
    input  logic                                in_last,
    output logic                                srt_rst_n,
    output logic [SIGNATURE_LEN-1:0]            srt_signature,
    output logic [INDICE_LEN-1:0]               srt_index,
    output logic                                srt_end_sorting,
    input  logic                                srt_sort_valid,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] srt_smallest_idx,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INDICES_COUNT*INDICE_LEN-1:0] out_indices,
    output logic [CNT_LEN-1:0]                  out_num_valid,
    output logic [CNT_LEN-1:0]                  out_count,
    output logic                                busy
);

    typedef enum logic [2:0] {
        CLEAR,
        STREAM,
        DRAIN,
        FINISH,
        PRESENT
    } state_t;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;
    // Largest value out_num_valid can show; a K beyond the counter range never clamps.
    localparam logic [CNT_LEN-1:0] K_CLAMP =
        (INDICES_COUNT >= (2 ** CNT_LEN)) ? CNT_MAX : CNT_LEN'(INDICES_COUNT);
    // The sorter compares strictly against an all-ones reset value, so this never inserts.
    localparam logic [SIGNATURE_LEN-1:0] FILLER_SIG = '1;

    state_t               state;
    state_t               state_next;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [CNT_LEN-1:0]   beat_cnt;
    logic [CNT_LEN-1:0]   ins_cnt;
    logic [CNT_LEN-1:0]   num_clamped;
    logic                 accept;
    logic                 capture;

    assign accept  = in_valid & in_ready;
    assign capture = (state == FINISH) & srt_sort_valid;

    // Sorter clear follows the system reset and is also held low for the CLEAR state.
    assign srt_rst_n = rst_n & (state != CLEAR);

    // Idle means waiting in STREAM for the first beat; reset itself reports not busy.
    assign busy = rst_n & ~((state == STREAM) && (beat_cnt == '0));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state handshake/control outputs.
    always_comb begin
        state_next      = state;
        in_ready        = 1'b0;
        srt_end_sorting = 1'b0;
        out_valid       = 1'b0;
        case (state)
            CLEAR: begin
                state_next = STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                srt_end_sorting = 1'b1;
                if (srt_sort_valid) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Sorter data path: pass accepted beats through, otherwise feed filler.
    always_comb begin
        srt_signature = FILLER_SIG;
        srt_index     = '0;
        if ((state == STREAM) && in_valid) begin
            srt_signature = in_signature;
            srt_index     = in_index;
        end
    end

    // Per-document beat/insert counters and the drain countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            ins_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    beat_cnt <= '0;
                    ins_cnt  <= '0;
                end
                STREAM: begin
                    if (accept) begin
                        if (beat_cnt != CNT_MAX) begin
                            beat_cnt <= beat_cnt + CNT_LEN'(1);
                        end
                        if ((in_signature != FILLER_SIG) && (ins_cnt != CNT_MAX)) begin
                            ins_cnt <= ins_cnt + CNT_LEN'(1);
                        end
                        if (in_last) begin
                            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Meaningful slot count is the inserted count limited to the sorter depth.
    always_comb begin
        num_clamped = ins_cnt;
        if (ins_cnt > K_CLAMP) begin
            num_clamped = K_CLAMP;
        end
    end

    // Result registers, loaded once when the sorter reports its final state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_indices   <= '0;
            out_count     <= '0;
            out_num_valid <= '0;
        end else if (capture) begin
            out_indices   <= srt_smallest_idx;
            out_count     <= beat_cnt;
            out_num_valid <= num_clamped;
        end
    end

endmodule

// File: tb/tb_proj_sorter_ctrl.sv
// Self-checking bench for proj_sorter_ctrl with a behavioural sorter attached.
// Stimulus pushes expected results into a scoreboard; a monitor pops and compares.
module tb_proj_sorter_ctrl;

    localparam int K   = 4;
    localparam int IL  = 16;
    localparam int SL  = 32;
    localparam int DC  = 2;
    localparam int CL  = 3;
    localparam int RW  = K * IL;
    localparam int CNT_MAX = (1 << CL) - 1;

    typedef struct {
        logic [RW-1:0] idx;
        logic [CL-1:0] cnt;
        logic [CL-1:0] num;
        int            expCyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SL-1:0] in_signature;
    logic [IL-1:0] in_index;
    logic          in_last;
    logic          srt_rst_n;
    logic [SL-1:0] srt_signature;
    logic [IL-1:0] srt_index;
    logic          srt_end_sorting;
    logic          srt_sort_valid;
    logic [RW-1:0] srt_smallest_idx;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_indices;
    logic [CL-1:0] out_num_valid;
    logic [CL-1:0] out_count;
    logic          busy;

    exp_t          sb[$];
    logic [SL-1:0] stimSig[$];
    logic [IL-1:0] stimIdx[$];
    int            nCompared   = 0;
    int            nMismatched = 0;
    int            nPushed     = 0;
    int            nResults    = 0;
    int            cyc         = 0;
    bit            armed       = 1'b0;

    proj_sorter_ctrl #(
        .INDICES_COUNT(K),
        .INDICE_LEN(IL),
        .SIGNATURE_LEN(SL),
        .DRAIN_CYCLES(DC),
        .CNT_LEN(CL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_signature(in_signature),
        .in_index(in_index),
        .in_last(in_last),
        .srt_rst_n(srt_rst_n),
        .srt_signature(srt_signature),
        .srt_index(srt_index),
        .srt_end_sorting(srt_end_sorting),
        .srt_sort_valid(srt_sort_valid),
        .srt_smallest_idx(srt_smallest_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_indices(out_indices),
        .out_num_valid(out_num_valid),
        .out_count(out_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sorter: insertion by strict less-than into K slots reset to all-ones.
    logic [SL-1:0] mSig[K];
    logic [IL-1:0] mIdx[K];

    function automatic int findSlot(logic [SL-1:0] s);
        int p = K;
        for (int i = K - 1; i >= 0; i--) begin
            if (s < mSig[i]) p = i;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (!srt_rst_n) begin
            for (int i = 0; i < K; i++) begin
                mSig[i] <= '1;
                mIdx[i] <= '0;
            end
        end else begin
            for (int i = 0; i < K; i++) begin
                if (i > findSlot(srt_signature)) begin
                    mSig[i] <= mSig[i-1];
                    mIdx[i] <= mIdx[i-1];
                end else if (i == findSlot(srt_signature)) begin
                    mSig[i] <= srt_signature;
                    mIdx[i] <= srt_index;
                end
            end
        end
    end

    always_comb begin
        srt_smallest_idx = '0;
        for (int i = 0; i < K; i++) begin
            srt_smallest_idx[i*IL +: IL] = mIdx[i];
        end
    end

    assign srt_sort_valid = srt_end_sorting;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: drop all-ones beats, then repeatedly take the earliest minimum.
    function automatic exp_t buildExpected(int expCyc);
        logic [SL-1:0] s[$];
        logic [IL-1:0] ix[$];
        exp_t          e;
        int            n;
        int            ins;
        int            best;
        n   = stimSig.size();
        ins = 0;
        for (int i = 0; i < n; i++) begin
            if (stimSig[i] != '1) begin
                s.push_back(stimSig[i]);
                ix.push_back(stimIdx[i]);
                ins++;
            end
        end
        e.idx = '0;
        for (int k = 0; k < K; k++) begin
            if (s.size() == 0) break;
            best = 0;
            for (int j = 1; j < s.size(); j++) begin
                if (s[j] < s[best]) best = j;
            end
            e.idx[k*IL +: IL] = ix[best];
            s.delete(best);
            ix.delete(best);
        end
        if (n > CNT_MAX) n = CNT_MAX;
        if (ins > CNT_MAX) ins = CNT_MAX;
        if (ins > K) ins = K;
        e.cnt    = CL'(n);
        e.num    = CL'(ins);
        e.expCyc = expCyc;
        return e;
    endfunction

    // Sends the loaded document; gapMode 0 = back-to-back, 1 = alternate idle, 2 = random idle.
    task automatic applyStimulus(input int gapMode);
        bit ok;
        int n;
        n = stimSig.size();
        for (int b = 0; b < n; b++) begin
            if ((gapMode == 1 && b > 0) || (gapMode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid     = 1'b1;
            in_signature = stimSig[b];
            in_index     = stimIdx[b];
            in_last      = (b == n - 1);
            ok = 1'b0;
            for (int w = 0; w < 100; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) checkOutput("in_ready_timeout", 64'(in_ready), 64'(1));
            if (ok && in_last) begin
                sb.push_back(buildExpected(cyc + DC + 2));
                nPushed++;
            end
            @(posedge clk);
            #1;
            in_valid     = 1'b0;
            in_last      = 1'b0;
            in_signature = $urandom;
            in_index     = IL'($urandom);
        end
    endtask

    // Waits for out_valid, holds out_ready low for 'hold' cycles, then completes the handshake.
    task automatic waitResult(input int hold);
        bit ok;
        if (hold == 0) out_ready = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("out_valid_timeout", 64'(out_valid), 64'(1));
            out_ready = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic loadDocA();
        stimSig = '{32'd50, 32'd10, 32'd40, 32'd20, 32'd30};
        stimIdx = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
    endtask

    task automatic loadDocOnes();
        stimSig = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF};
        stimIdx = '{16'd5, 16'd9, 16'd6};
    endtask

    // Monitor: pops the scoreboard on each new result and checks hold/handshake behaviour.
    initial begin
        bit            prevValid;
        int            hsCyc;
        logic [RW-1:0] heldIdx;
        logic [CL-1:0] heldCnt;
        logic [CL-1:0] heldNum;
        exp_t          e;
        prevValid = 1'b0;
        hsCyc     = -100;
        heldIdx   = '0;
        heldCnt   = '0;
        heldNum   = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (in_valid && in_ready) begin
                    checkOutput("srt_sig_pass", 64'(srt_signature), 64'(in_signature));
                    checkOutput("srt_idx_pass", 64'(srt_index), 64'(in_index));
                end else begin
                    checkOutput("filler_sig", 64'(srt_signature), 64'({SL{1'b1}}));
                    checkOutput("filler_idx", 64'(srt_index), 64'(0));
                end
                if (!rst_n) begin
                    prevValid = 1'b0;
                    hsCyc     = -100;
                end else begin
                    if (cyc == hsCyc + 1) begin
                        checkOutput("hs1_in_ready", 64'(in_ready), 64'(0));
                        checkOutput("hs1_srt_rst_n", 64'(srt_rst_n), 64'(0));
                        checkOutput("hs1_out_valid", 64'(out_valid), 64'(0));
                    end
                    if (cyc == hsCyc + 2) begin
                        checkOutput("hs2_in_ready", 64'(in_ready), 64'(1));
                        checkOutput("hs2_srt_rst_n", 64'(srt_rst_n), 64'(1));
                    end
                    if (out_valid && !prevValid) begin
                        nResults++;
                        if (sb.size() == 0) begin
                            checkOutput("unexpected_result", 64'(out_valid), 64'(0));
                        end else begin
                            e = sb.pop_front();
                            checkOutput("out_indices", 64'(out_indices), 64'(e.idx));
                            checkOutput("out_count", 64'(out_count), 64'(e.cnt));
                            checkOutput("out_num_valid", 64'(out_num_valid), 64'(e.num));
                            checkOutput("result_latency", 64'(cyc), 64'(e.expCyc));
                        end
                        heldIdx = out_indices;
                        heldCnt = out_count;
                        heldNum = out_num_valid;
                    end else if (out_valid) begin
                        checkOutput("hold_indices", 64'(out_indices), 64'(heldIdx));
                        checkOutput("hold_count", 64'(out_count), 64'(heldCnt));
                        checkOutput("hold_num", 64'(out_num_valid), 64'(heldNum));
                        checkOutput("hold_in_ready", 64'(in_ready), 64'(0));
                    end
                    if (out_valid && out_ready) hsCyc = cyc;
                    prevValid = out_valid;
                end
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int len;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_signature = '0;
        in_index     = '0;
        out_ready    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_indices", 64'(out_indices), 64'(0));
        checkOutput("rst_out_count", 64'(out_count), 64'(0));
        checkOutput("rst_out_num_valid", 64'(out_num_valid), 64'(0));
        checkOutput("rst_end_sorting", 64'(srt_end_sorting), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_srt_rst_n", 64'(srt_rst_n), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("clear_in_ready", 64'(in_ready), 64'(0));
        checkOutput("clear_srt_rst_n", 64'(srt_rst_n), 64'(0));
        checkOutput("clear_busy", 64'(busy), 64'(1));
        @(negedge clk);
        checkOutput("stream_in_ready", 64'(in_ready), 64'(1));
        checkOutput("stream_idle_busy", 64'(busy), 64'(0));
        checkOutput("stream_srt_rst_n", 64'(srt_rst_n), 64'(1));
        @(posedge clk);
        #1;

        $display("[TB] basic document, back-to-back beats");
        loadDocA();
        applyStimulus(0);
        @(negedge clk);
        checkOutput("drain_busy", 64'(busy), 64'(1));
        checkOutput("drain_in_ready", 64'(in_ready), 64'(0));
        waitResult(0);

        $display("[TB] same document with idle gaps");
        loadDocA();
        applyStimulus(1);
        waitResult(1);

        $display("[TB] all-ones signatures are not inserted");
        loadDocOnes();
        applyStimulus(0);
        waitResult(0);

        $display("[TB] extended back-pressure then a fresh document");
        loadDocA();
        applyStimulus(0);
        waitResult(10);
        loadDocOnes();
        applyStimulus(0);
        waitResult(0);

        $display("[TB] reset during drain");
        loadDocA();
        applyStimulus(0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_end_sorting", 64'(srt_end_sorting), 64'(0));
        checkOutput("abort_srt_rst_n", 64'(srt_rst_n), 64'(0));
        void'(sb.pop_back());
        nPushed--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort_no_result", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        loadDocA();
        applyStimulus(2);
        waitResult(2);

        $display("[TB] counter saturation");
        stimSig.delete();
        stimIdx.delete();
        for (int i = 0; i < 10; i++) begin
            stimSig.push_back(SL'($urandom_range(0, 1000)));
            stimIdx.push_back(IL'(i + 100));
        end
        applyStimulus(0);
        waitResult(0);

        $display("[TB] empty document");
        stimSig = '{32'hFFFF_FFFF};
        stimIdx = '{16'd3};
        applyStimulus(0);
        waitResult(1);

        $display("[TB] randomized documents");
        for (int d = 0; d < 25; d++) begin
            stimSig.delete();
            stimIdx.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) stimSig.push_back('1);
                else stimSig.push_back(SL'($urandom_range(0, 30)));
                stimIdx.push_back(IL'($urandom_range(0, 65535)));
            end
            applyStimulus(2);
            waitResult($urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
        checkOutput("result_count", 64'(nResults), 64'(nPushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
